// File: rtl/uc_core_param_pkg.sv
// Shared opcode/state types and the width-generic ALU evaluation used by uc_core_param.
package uc_core_pkg;

  localparam int unsigned ALU_MAX_W = 16;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_IN   = 4'h1,
    OP_OUT  = 4'h2,
    OP_JMP  = 4'h3,
    OP_BEQ  = 4'h4,
    OP_BC   = 4'h5,
    OP_LDI  = 4'h6,
    OP_MOV  = 4'h7,
    OP_ADD  = 4'h8,
    OP_SUB  = 4'h9,
    OP_AND  = 4'hA,
    OP_OR   = 4'hB,
    OP_XOR  = 4'hC,
    OP_CMP  = 4'hD,
    OP_ADC  = 4'hE,
    OP_HALT = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  // Operands arrive zero-extended to ALU_MAX_W; dw is the live width. Carry/borrow is bit dw.
  function automatic logic [ALU_MAX_W:0] alu_eval(input opcode_e op,
                                                  input logic [ALU_MAX_W-1:0] a,
                                                  input logic [ALU_MAX_W-1:0] b,
                                                  input logic cin,
                                                  input logic [4:0] dw);
    logic [ALU_MAX_W:0]   ext_a;
    logic [ALU_MAX_W:0]   ext_b;
    logic [ALU_MAX_W:0]   raw;
    logic [ALU_MAX_W:0]   one_v;
    logic [ALU_MAX_W-1:0] mask;
    logic                 carry;
    ext_a = {1'b0, a};
    ext_b = {1'b0, b};
    one_v = {{ALU_MAX_W{1'b0}}, 1'b1};
    mask  = ALU_MAX_W'((one_v << dw) - one_v);
    case (op)
      OP_ADD:         raw = ext_a + ext_b;
      OP_ADC:         raw = ext_a + ext_b + {{ALU_MAX_W{1'b0}}, cin};
      OP_SUB, OP_CMP: raw = ext_a - ext_b;
      OP_AND:         raw = ext_a & ext_b;
      OP_OR:          raw = ext_a | ext_b;
      OP_XOR:         raw = ext_a ^ ext_b;
      default:        raw = {(ALU_MAX_W+1){1'b0}};
    endcase
    if (op inside {OP_ADD, OP_ADC, OP_SUB, OP_CMP}) begin
      carry = raw[dw];
    end else begin
      carry = cin;
    end
    return {carry, raw[ALU_MAX_W-1:0] & mask};
  endfunction

endpackage

// File: rtl/uc_core_param_alu.sv
// Combinational DATA_W-generic ALU wrapper around uc_core_pkg::alu_eval.
module uc_alu_param
  import uc_core_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  opcode_e           i_op,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic              i_cin,
  output logic [DATA_W-1:0] o_result,
  output logic              o_carry,
  output logic              o_zero
);

  logic [ALU_MAX_W:0] w_eval;

  assign w_eval   = alu_eval(i_op, ALU_MAX_W'(i_a), ALU_MAX_W'(i_b), i_cin, 5'(DATA_W));
  assign o_result = DATA_W'(w_eval[ALU_MAX_W-1:0]);
  assign o_carry  = w_eval[ALU_MAX_W];
  // Bits above DATA_W are already masked to zero, so the full vector is a valid zero test.
  assign o_zero   = (w_eval[ALU_MAX_W-1:0] == {ALU_MAX_W{1'b0}});

endmodule

// File: rtl/uc_core_param.sv
// Parametrised multicycle fetch/execute microcontroller core with flash wait-states,
// carry-chained arithmetic, logic ops, HALT and indexed output ports.
module uc_core_param
  import uc_core_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int PC_W     = 12,
  parameter int NREGS    = 16,
  parameter int NOUT     = 2,
  parameter int BOOT_CYC = 4
) (
  input  logic                   clk,
  input  logic                   arst_n,
  output logic [PC_W-1:0]        pc_out,
  input  logic [DATA_W+7:0]      flash_data,
  input  logic                   flash_valid,
  input  logic [DATA_W-1:0]      in,
  output logic [NOUT*DATA_W-1:0] out,
  output logic                   bootstrapping,
  output logic [1:0]             cu_state,
  output logic                   halted,
  output logic                   equal_flag,
  output logic                   carry_flag
);

  localparam int IW    = DATA_W + 8;
  localparam int CNT_W = (BOOT_CYC > 1) ? $clog2(BOOT_CYC) : 1;

  state_e                r_state;
  logic [PC_W-1:0]       r_pc;
  logic [IW-1:0]         r_instr;
  logic [DATA_W-1:0]     r_regs [NREGS];
  logic [NOUT*DATA_W-1:0] r_out;
  logic                  r_eq;
  logic                  r_cy;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_boot;
  logic                  r_halted;

  opcode_e           w_op;
  logic [3:0]        w_rd;
  logic [3:0]        w_ra;
  logic [3:0]        w_rb;
  logic [3:0]        w_port;
  logic [DATA_W-1:0] w_imm;
  logic [PC_W-1:0]   w_target;
  logic [DATA_W-1:0] w_rd_val;
  logic [DATA_W-1:0] w_ra_val;
  logic [DATA_W-1:0] w_rb_val;
  logic [DATA_W-1:0] w_alu_res;
  logic              w_alu_cy;
  logic              w_alu_zero;
  logic              w_taken;
  logic              w_wr_en;
  logic [DATA_W-1:0] w_wr_data;
  logic              w_flag_arith;
  logic              w_flag_logic;

  assign w_op     = opcode_e'(r_instr[IW-1 -: 4]);
  assign w_rd     = r_instr[IW-5 -: 4];
  assign w_ra     = r_instr[IW-9 -: 4];
  // The rb field runs off the bottom of the word for narrow DATA_W; missing bits read as zero.
  assign w_rb     = 4'({r_instr, 4'b0000} >> (IW - 12));
  assign w_port   = r_instr[3:0];
  assign w_imm    = r_instr[DATA_W-1:0];
  assign w_target = r_instr[PC_W-1:0];

  // Three read ports; addresses at or beyond NREGS read as zero.
  always_comb begin
    w_rd_val = {DATA_W{1'b0}};
    w_ra_val = {DATA_W{1'b0}};
    w_rb_val = {DATA_W{1'b0}};
    for (int i = 0; i < NREGS; i++) begin
      w_rd_val = (w_rd == 4'(i)) ? r_regs[i] : w_rd_val;
      w_ra_val = (w_ra == 4'(i)) ? r_regs[i] : w_ra_val;
      w_rb_val = (w_rb == 4'(i)) ? r_regs[i] : w_rb_val;
    end
  end

  uc_alu_param #(.DATA_W(DATA_W)) u_alu (
    .i_op     (w_op),
    .i_a      (w_ra_val),
    .i_b      (w_rb_val),
    .i_cin    (r_cy),
    .o_result (w_alu_res),
    .o_carry  (w_alu_cy),
    .o_zero   (w_alu_zero)
  );

  // Opcode decode: writeback source, flag update class and branch decision.
  always_comb begin
    w_wr_en      = 1'b0;
    w_wr_data    = w_alu_res;
    w_flag_arith = 1'b0;
    w_flag_logic = 1'b0;
    w_taken      = 1'b0;
    case (w_op)
      OP_IN:  begin w_wr_en = 1'b1; w_wr_data = in;       end
      OP_LDI: begin w_wr_en = 1'b1; w_wr_data = w_imm;    end
      OP_MOV: begin w_wr_en = 1'b1; w_wr_data = w_ra_val; end
      OP_ADD, OP_SUB, OP_ADC: begin w_wr_en = 1'b1; w_flag_arith = 1'b1; end
      OP_CMP: w_flag_arith = 1'b1;
      OP_AND, OP_OR, OP_XOR:  begin w_wr_en = 1'b1; w_flag_logic = 1'b1; end
      OP_JMP: w_taken = 1'b1;
      OP_BEQ: w_taken = r_eq;
      OP_BC:  w_taken = r_cy;
      default: w_wr_en = 1'b0;
    endcase
  end

  // Control sequencer with program counter, register file, output ports and flags.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      r_state  <= ST_BOOT;
      r_pc     <= {PC_W{1'b0}};
      r_instr  <= {IW{1'b0}};
      r_out    <= {(NOUT*DATA_W){1'b0}};
      r_eq     <= 1'b0;
      r_cy     <= 1'b0;
      r_cnt    <= {CNT_W{1'b0}};
      r_boot   <= 1'b1;
      r_halted <= 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= {DATA_W{1'b0}};
      end
    end else begin
      case (r_state)
        ST_BOOT: begin
          if (r_cnt == CNT_W'(BOOT_CYC - 1)) begin
            r_state <= ST_FETCH;
            r_boot  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_FETCH: begin
          if (flash_valid) begin
            r_instr <= flash_data;
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (w_op == OP_HALT) begin
            r_state  <= ST_HALT;
            r_halted <= 1'b1;
          end else begin
            r_state <= ST_FETCH;
            r_pc    <= w_taken ? w_target : r_pc + PC_W'(1);
          end
          for (int i = 0; i < NREGS; i++) begin
            if (w_wr_en && (w_rd == 4'(i))) begin
              r_regs[i] <= w_wr_data;
            end
          end
          for (int k = 0; k < NOUT; k++) begin
            if ((w_op == OP_OUT) && (w_port == 4'(k))) begin
              r_out[k*DATA_W +: DATA_W] <= w_rd_val;
            end
          end
          // Logic ops refresh equal but leave carry as it was.
          if (w_flag_arith) begin
            r_eq <= w_alu_zero;
            r_cy <= w_alu_cy;
          end else if (w_flag_logic) begin
            r_eq <= w_alu_zero;
          end
        end
        ST_HALT: r_state <= ST_HALT;
        default: r_state <= ST_BOOT;
      endcase
    end
  end

  assign pc_out        = r_pc;
  assign out           = r_out;
  assign bootstrapping = r_boot;
  assign cu_state      = r_state;
  assign halted        = r_halted;
  assign equal_flag    = r_eq;
  assign carry_flag    = r_cy;

endmodule

// File: tb/tb_uc_core_param.sv
// Self-checking bench for uc_core_param: directed vector table, multi-cycle corner
// sequences, and random instruction streams against an instruction-level reference model.
module tb_uc_core_param;

  localparam int DW    = 8;
  localparam int PCW   = 12;
  localparam int NO    = 2;
  localparam int DMOD  = 256;
  localparam int PCMOD = 4096;

  logic            clk;
  logic            arst_n;
  logic [PCW-1:0]  pc_out;
  logic [DW+7:0]   flash_data;
  logic            flash_valid;
  logic [DW-1:0]   tb_in;
  logic [NO*DW-1:0] tb_out;
  logic            bootstrapping;
  logic [1:0]      cu_state;
  logic            halted;
  logic            equal_flag;
  logic            carry_flag;

  int n_checks = 0;
  int n_fail   = 0;

  // Instruction-level reference state
  int m_reg [16];
  int m_out [NO];
  int m_eq, m_cy, m_pc, m_halt;

  typedef struct {
    logic [15:0] ins;
    logic [7:0]  inv;
    int          stalls;
    logic [11:0] pc;
    logic [15:0] outv;
    logic        eq;
    logic        cy;
  } vec_t;

  vec_t vecs [35];

  uc_core_param #(.DATA_W(DW), .PC_W(PCW), .NREGS(16), .NOUT(NO), .BOOT_CYC(4)) dut (
    .clk           (clk),
    .arst_n        (arst_n),
    .pc_out        (pc_out),
    .flash_data    (flash_data),
    .flash_valid   (flash_valid),
    .in            (tb_in),
    .out           (tb_out),
    .bootstrapping (bootstrapping),
    .cu_state      (cu_state),
    .halted        (halted),
    .equal_flag    (equal_flag),
    .carry_flag    (carry_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_reg[i] = 0;
    for (int k = 0; k < NO; k++) m_out[k] = 0;
    m_eq = 0; m_cy = 0; m_pc = 0; m_halt = 0;
  endtask

  // Architectural effect of one instruction, from the ISA rules.
  task automatic model_step(input logic [15:0] ins, input int inv);
    int op, rd, a, b, r, nxt, tgt;
    op  = int'(ins[15:12]);
    rd  = int'(ins[11:8]);
    a   = m_reg[int'(ins[7:4])];
    b   = m_reg[int'(ins[3:0])];
    tgt = int'(ins[11:0]);
    nxt = (m_pc + 1) % PCMOD;
    case (op)
      1:  m_reg[rd] = inv;
      2:  if (int'(ins[3:0]) < NO) m_out[int'(ins[3:0])] = m_reg[rd];
      3:  nxt = tgt;
      4:  if (m_eq != 0) nxt = tgt;
      5:  if (m_cy != 0) nxt = tgt;
      6:  m_reg[rd] = int'(ins[7:0]);
      7:  m_reg[rd] = a;
      8, 14: begin
        r = a + b + ((op == 14) ? m_cy : 0);
        m_cy = (r >= DMOD) ? 1 : 0;
        m_reg[rd] = r % DMOD;
        m_eq = (r % DMOD == 0) ? 1 : 0;
      end
      9, 13: begin
        m_cy = (a < b) ? 1 : 0;
        r = (a - b + DMOD) % DMOD;
        m_eq = (r == 0) ? 1 : 0;
        if (op == 9) m_reg[rd] = r;
      end
      10, 11, 12: begin
        r = (op == 10) ? (a & b) : (op == 11) ? (a | b) : (a ^ b);
        m_reg[rd] = r;
        m_eq = (r == 0) ? 1 : 0;
      end
      15: begin m_halt = 1; nxt = m_pc; end
      default: ;
    endcase
    m_pc = nxt;
  endtask

  // Entered at a negedge in FETCH; returns at the negedge after EXEC.
  task automatic exec_one(input logic [15:0] ins, input logic [7:0] inv, input int stalls);
    logic [11:0] pc0;
    pc0 = pc_out;
    tb_in = inv;
    for (int s = 0; s < stalls; s++) begin
      flash_valid = 1'b0;
      flash_data  = 16'($urandom);
      @(negedge clk);
      check("stall_state", cu_state, 32'd1);
      check("stall_pc", pc_out, pc0);
    end
    flash_valid = 1'b1;
    flash_data  = ins;
    @(negedge clk);
    check("exec_state", cu_state, 32'd2);
    check("exec_pc", pc_out, pc0);
    flash_valid = 1'($urandom);
    flash_data  = 16'($urandom);
    @(negedge clk);
    flash_valid = 1'b0;
  endtask

  task automatic reset_and_boot();
    arst_n = 1'b0; flash_valid = 1'b0; flash_data = 16'h0000; tb_in = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_state", cu_state, 32'd0);
    check("rst_pc", pc_out, 32'd0);
    check("rst_out", tb_out, 32'd0);
    check("rst_flags", {equal_flag, carry_flag}, 32'd0);
    check("rst_halted", halted, 32'd0);
    arst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("boot_flag", bootstrapping, 32'd1);
      check("boot_pc", pc_out, 32'd0);
      flash_valid = 1'b1;
      @(negedge clk);
    end
    flash_valid = 1'b0;
    check("boot_done_state", cu_state, 32'd1);
    check("boot_done_flag", bootstrapping, 32'd0);
    model_reset();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ins;
    logic [7:0]  inv;

    vecs[0]  = '{16'h0000, 8'h00, 0, 12'h001, 16'h0000, 1'b0, 1'b0};
    vecs[1]  = '{16'h0000, 8'h00, 0, 12'h002, 16'h0000, 1'b0, 1'b0};
    vecs[2]  = '{16'h61F0, 8'h00, 1, 12'h003, 16'h0000, 1'b0, 1'b0};
    vecs[3]  = '{16'h6220, 8'h00, 0, 12'h004, 16'h0000, 1'b0, 1'b0};
    vecs[4]  = '{16'h8312, 8'h00, 0, 12'h005, 16'h0000, 1'b0, 1'b1};
    vecs[5]  = '{16'hE412, 8'h00, 0, 12'h006, 16'h0000, 1'b0, 1'b1};
    vecs[6]  = '{16'h2300, 8'h00, 0, 12'h007, 16'h0010, 1'b0, 1'b1};
    vecs[7]  = '{16'h2401, 8'h00, 0, 12'h008, 16'h1110, 1'b0, 1'b1};
    vecs[8]  = '{16'h6105, 8'h00, 0, 12'h009, 16'h1110, 1'b0, 1'b1};
    vecs[9]  = '{16'h6205, 8'h00, 0, 12'h00A, 16'h1110, 1'b0, 1'b1};
    vecs[10] = '{16'hD012, 8'h00, 0, 12'h00B, 16'h1110, 1'b1, 1'b0};
    vecs[11] = '{16'h40A0, 8'h00, 0, 12'h0A0, 16'h1110, 1'b1, 1'b0};
    vecs[12] = '{16'h6103, 8'h00, 0, 12'h0A1, 16'h1110, 1'b1, 1'b0};
    vecs[13] = '{16'h6207, 8'h00, 0, 12'h0A2, 16'h1110, 1'b1, 1'b0};
    vecs[14] = '{16'h9612, 8'h00, 0, 12'h0A3, 16'h1110, 1'b0, 1'b1};
    vecs[15] = '{16'h5123, 8'h00, 0, 12'h123, 16'h1110, 1'b0, 1'b1};
    vecs[16] = '{16'h2600, 8'h00, 0, 12'h124, 16'h11FC, 1'b0, 1'b1};
    vecs[17] = '{16'h9621, 8'h00, 0, 12'h125, 16'h11FC, 1'b0, 1'b0};
    vecs[18] = '{16'h5123, 8'h00, 0, 12'h126, 16'h11FC, 1'b0, 1'b0};
    vecs[19] = '{16'h1500, 8'h5A, 0, 12'h127, 16'h11FC, 1'b0, 1'b0};
    vecs[20] = '{16'h2501, 8'h00, 0, 12'h128, 16'h5AFC, 1'b0, 1'b0};
    vecs[21] = '{16'h2503, 8'h00, 0, 12'h129, 16'h5AFC, 1'b0, 1'b0};
    vecs[22] = '{16'h68FF, 8'h00, 0, 12'h12A, 16'h5AFC, 1'b0, 1'b0};
    vecs[23] = '{16'h8988, 8'h00, 0, 12'h12B, 16'h5AFC, 1'b0, 1'b1};
    vecs[24] = '{16'hC755, 8'h00, 0, 12'h12C, 16'h5AFC, 1'b1, 1'b1};
    vecs[25] = '{16'hB750, 8'h00, 0, 12'h12D, 16'h5AFC, 1'b0, 1'b1};
    vecs[26] = '{16'hA750, 8'h00, 0, 12'h12E, 16'h5AFC, 1'b1, 1'b1};
    vecs[27] = '{16'h7A50, 8'h00, 0, 12'h12F, 16'h5AFC, 1'b1, 1'b1};
    vecs[28] = '{16'h2A00, 8'h00, 0, 12'h130, 16'h5A5A, 1'b1, 1'b1};
    vecs[29] = '{16'h0000, 8'h00, 3, 12'h131, 16'h5A5A, 1'b1, 1'b1};
    vecs[30] = '{16'hD098, 8'h00, 0, 12'h132, 16'h5A5A, 1'b0, 1'b1};
    vecs[31] = '{16'h3FFF, 8'h00, 0, 12'hFFF, 16'h5A5A, 1'b0, 1'b1};
    vecs[32] = '{16'h0000, 8'h00, 0, 12'h000, 16'h5A5A, 1'b0, 1'b1};
    vecs[33] = '{16'h3000, 8'h00, 0, 12'h000, 16'h5A5A, 1'b0, 1'b1};
    vecs[34] = '{16'hEB88, 8'h00, 0, 12'h001, 16'h5A5A, 1'b0, 1'b1};

    reset_and_boot();
    for (int v = 0; v < 35; v++) begin
      exec_one(vecs[v].ins, vecs[v].inv, vecs[v].stalls);
      check("vec_pc", pc_out, vecs[v].pc);
      check("vec_out", tb_out, vecs[v].outv);
      check("vec_eq", equal_flag, vecs[v].eq);
      check("vec_cy", carry_flag, vecs[v].cy);
      check("vec_state", cu_state, 32'd1);
    end

    // HALT is terminal: pc and ports freeze even with flash offering data.
    exec_one(16'hF000, 8'h00, 0);
    check("halt_state", cu_state, 32'd3);
    check("halt_flag", halted, 32'd1);
    for (int i = 0; i < 3; i++) begin
      flash_valid = 1'b1;
      flash_data  = 16'($urandom);
      @(negedge clk);
      check("halt_pc_hold", pc_out, 32'h001);
      check("halt_out_hold", tb_out, 32'h5A5A);
      check("halt_state_hold", cu_state, 32'd3);
    end

    // Reset landing during EXEC of an ADD must discard its writeback.
    reset_and_boot();
    exec_one(16'h61F0, 8'h00, 0);
    exec_one(16'h6220, 8'h00, 0);
    exec_one(16'h8312, 8'h00, 0);
    exec_one(16'h2100, 8'h00, 0);
    check("pre_rst_out", tb_out, 32'h00F0);
    check("pre_rst_cy", carry_flag, 32'd1);
    flash_valid = 1'b1;
    flash_data  = 16'h8512;
    @(negedge clk);
    check("mid_exec_state", cu_state, 32'd2);
    arst_n = 1'b0;
    flash_valid = 1'b0;
    @(negedge clk);
    check("mid_rst_state", cu_state, 32'd0);
    check("mid_rst_pc", pc_out, 32'd0);
    check("mid_rst_out", tb_out, 32'd0);
    check("mid_rst_flags", {equal_flag, carry_flag}, 32'd0);
    check("mid_rst_boot", bootstrapping, 32'd1);
    arst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("mid_rst_fetch", cu_state, 32'd1);
    exec_one(16'h2500, 8'h00, 0);
    check("mid_rst_r5", tb_out, 32'h0000);
    exec_one(16'h2101, 8'h00, 0);
    check("mid_rst_r1", tb_out, 32'h0000);

    // Random instruction stream against the reference model.
    reset_and_boot();
    for (int n = 0; n < 250; n++) begin
      ins = 16'($urandom);
      ins[15:12] = 4'($urandom_range(0, 14));
      inv = 8'($urandom);
      check("rand_pre_pc", pc_out, m_pc);
      exec_one(ins, inv, $urandom_range(0, 2));
      model_step(ins, int'(inv));
      check("rand_pc", pc_out, m_pc);
      check("rand_out", tb_out, {m_out[1][7:0], m_out[0][7:0]});
      check("rand_eq", equal_flag, m_eq);
      check("rand_cy", carry_flag, m_cy);
      check("rand_state", cu_state, 32'd1);
    end
    exec_one(16'hF000, 8'h00, 1);
    model_step(16'hF000, 0);
    check("rand_halt_flag", halted, m_halt);
    for (int i = 0; i < 3; i++) begin
      flash_valid = 1'b1;
      @(negedge clk);
      check("rand_halt_pc", pc_out, m_pc);
      check("rand_halt_state", cu_state, 32'd3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uc_core_param.md
Name: uc_core_param

Overview:
- Parametrised successor to the 8-bit microcontroller core: a multicycle fetch/execute CPU with a generic data width, register-file depth and output-port count.
- Adds the following beyond the 8-bit core:
  - flash wait-state handshake
  - add-with-carry
  - logic ops
  - HALT
  - indexed output ports
- Sits between program flash and the IO pins; the existing FV bind checker pattern (ADD/SUB/JMP/BC/BEQ/IN sequences) carries over with DELAY generalised.

Parameters:
- DATA_W, 8, datapath and register width (4..16).
- PC_W, 12, program counter width; must be ≤ DATA_W+4.
- NREGS, 16, register-file entries (2..16); register addresses are 4 bits, and addresses ≥ NREGS read 0 and ignore writes.
- NOUT, 2, output ports (1..16).
- BOOT_CYC, 4, cycles held in BOOT after reset release.

Ports:
- clk  in  1  core clock.
- arst_n  in  1  reset, synchronous, active-low (name kept from codebase).
- pc_out  out  PC_W  flash address.
- flash_data  in  DATA_W+8  instruction word.
- flash_valid  in  1  flash_data valid for pc_out this cycle.
- in  in  DATA_W  input port.
- out  out  NOUT*DATA_W  output ports, port k at bits [k*DATA_W +: DATA_W].
- bootstrapping  out  1  high while in BOOT.
- cu_state  out  2  current state encoding.
- halted  out  1  high in HALT.
- equal_flag  out  1  registered zero/equal flag.
- carry_flag  out  1  registered carry/borrow flag.

Behaviour:
- Instruction format: op = instr[IW-1:IW-4], where IW = DATA_W+8.
  - rd = instr[IW-5:IW-8].
  - Register form: ra = instr[IW-9:IW-12], rb = instr[IW-13:IW-16].
  - Immediate form: imm = instr[DATA_W-1:0].
  - Branch form: target = instr[PC_W-1:0].
- Opcodes:
  - 0 NOP.
  - 1 IN: rd <= in.
  - 2 OUT: port[instr[3:0]] <= reg[rd]; port index ≥ NOUT is ignored.
  - 3 JMP.
  - 4 BEQ (taken if equal_flag).
  - 5 BC (taken if carry_flag).
  - 6 LDI: rd <= imm.
  - 7 MOV: rd <= ra.
  - 8 ADD.
  - 9 SUB: ra - rb.
  - A AND.
  - B OR.
  - C XOR.
  - D CMP (SUB without writeback).
  - E ADC: ra + rb + carry_flag.
  - F HALT.
- States (cu_state): BOOT=0, FETCH=1, EXEC=2, HALT=3.
- Reset (arst_n low at posedge):
  - state=BOOT, pc=0.
  - All regs, out, flags = 0.
  - bootstrapping=1, halted=0.
  - Applies mid-instruction; no partial writeback survives.
- BOOT: counter runs BOOT_CYC cycles, then FETCH; pc_out=0 throughout.
- FETCH: if flash_valid, latch instr and go to EXEC; otherwise stay in FETCH (wait-state).
- EXEC (one cycle): perform the op, then go to FETCH.
  - pc <= target if jump taken; otherwise pc+1, wrapping modulo 2^PC_W.
  - HALT goes to the HALT state instead.
- Nominal latency is 2 cycles per instruction with zero wait-states; a result is visible in reg/out/flags the cycle after EXEC.
- HALT: terminal until reset; pc holds and outputs hold.
- Arithmetic is computed at DATA_W+1 bits.
  - carry = bit DATA_W. For SUB/CMP it is the borrow (1 when ra<rb unsigned).
  - equal = (DATA_W-bit result == 0).
  - Flags update only on ADD/SUB/CMP/ADC; logic ops update equal only, clearing carry is not done.
  - All other ops leave the flags unchanged.
- Register read in EXEC sees the prior writeback; there is no forwarding hazard, since writes commit at the end of EXEC.
- flash_valid is ignored outside FETCH.
- A branch to the current pc is legal (self-loop).

Decomposition:
- Package uc_core_pkg:
  - opcode enum (4-bit).
  - state enum (2-bit).
  - function alu_eval(op, a, b, cin) returning {carry, result}.
- One sub-module, uc_alu_param: combinational, DATA_W-generic; takes op/a/b/cin and returns result/carry/zero. FV reuses it as the WhiteBox target.

Test Plan:
- Reset, 4 idle cycles, then NOPs with flash_valid=1:
  - bootstrapping=1 for 4 cycles.
  - pc_out then steps 0,0,1,1,2 across FETCH/EXEC.
- LDI r1,0xF0; LDI r2,0x20; ADD r3,r1,r2; ADC r4,r1,r2 (DATA_W=8):
  - r3=0x10, carry=1.
  - ADC gives r4=0x11.
- LDI r1,5; LDI r2,5; CMP r1,r2; BEQ 0x0A0:
  - equal=1.
  - pc_out=0x0A0 in the FETCH after BEQ.
- SUB 3-7:
  - result 0xFC, carry=1.
  - BC 0x123 is taken; the same sequence with 7-3 falls through to pc+1.
- IN r5 with in=0x5A, OUT r5→port1 (NOUT=2):
  - out[15:8]=0x5A, out[7:0] unchanged.
  - OUT to port 3 leaves both ports unchanged.
- Hold flash_valid=0 for 3 cycles in FETCH:
  - state stays FETCH and pc_out holds.
- HALT:
  - halted=1 and no further pc change.
- Assert arst_n=0 during EXEC of ADD:
  - no writeback, all zero, state=BOOT.
